// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the LEGv8 hazard unit: shadow-slot layout, forward-select
// codes, the XZR default index and the bubble (NOP) slot encoding.
package pipe_pkg;

    localparam int REG_AW_MAX   = 8;
    localparam int ZERO_REG_DEF = 31;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr;
        logic                  load;
        logic                  setflag;
        logic [REG_AW_MAX-1:0] rn;
        logic [REG_AW_MAX-1:0] rm;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Bubble: invalid, and every register field parked on XZR so it never matches.
    function automatic slot_t nop_slot(input logic [REG_AW_MAX-1:0] zr);
        slot_t s;
        s         = '0;
        s.rd      = zr;
        s.rn      = zr;
        s.rm      = zr;
        return s;
    endfunction

    function automatic logic slot_match(input logic                  valid,
                                        input logic                  wr,
                                        input logic [REG_AW_MAX-1:0] rd,
                                        input logic [REG_AW_MAX-1:0] r,
                                        input logic [REG_AW_MAX-1:0] zr);
        return valid & wr & (rd == r) & (r != zr);
    endfunction

endpackage

// File: rtl/pipe_fwd_mux.sv
// Operand forwarding select: MEM (non-load) beats WB beats register file.
module pipe_fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [REG_AW_MAX-1:0] src,
    input  logic                  mem_valid,
    input  logic                  mem_wr,
    input  logic                  mem_load,
    input  logic [REG_AW_MAX-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_wr,
    input  logic [REG_AW_MAX-1:0] wb_rd,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     data
);

    localparam logic [REG_AW_MAX-1:0] ZR = REG_AW_MAX'(ZERO_REG);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = slot_match(mem_valid, mem_wr, mem_rd, src, ZR) & ~mem_load;
    assign wb_hit  = slot_match(wb_valid, wb_wr, wb_rd, src, ZR);

    always_comb begin
        sel  = FWD_RF;
        data = rf_data;
        if (mem_hit) begin
            sel  = FWD_MEM;
            data = mem_data;
        end else if (wb_hit) begin
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall / bubble / flush and forwarding control for the 5-stage LEGv8 pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall and flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_setflag,
    input  logic              id_flagbr,
    input  logic              id_cbr,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ex_rf_a,
    input  logic [DATA_W-1:0] ex_rf_b,
    input  logic [DATA_W-1:0] id_rf_a,
    input  logic [DATA_W-1:0] id_rf_b,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [DATA_W-1:0] id_opa,
    output logic [DATA_W-1:0] id_opb,
    output logic              stall,
    output logic              idex_bubble,
    output logic              ifid_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    localparam logic [REG_AW_MAX-1:0] ZR = REG_AW_MAX'(ZERO_REG);

    function automatic logic [REG_AW_MAX-1:0] ext(input logic [REG_AW-1:0] r);
        logic [REG_AW_MAX-1:0] e;
        e             = '0;
        e[REG_AW-1:0] = r;
        return e;
    endfunction

    slot_t                 id_p0, ex_p1, mem_p2, wb_p3;
    logic [REG_AW_MAX-1:0] rn_p0, rm_p0;
    logic                  ex_vld, mem_vld, wb_vld;
    logic                  ex_hit_a, ex_hit_b, mem_ld_a, mem_ld_b;
    logic                  load_use, cbr_haz, flag_haz;
    logic [1:0]            id_sel_a, id_sel_b;

    assign rn_p0 = ext(id_rn);
    assign rm_p0 = ext(id_rm);

    always_comb begin
        id_p0 = '{valid: 1'b1, rd: ext(id_rd), wr: id_wr, load: id_load,
                  setflag: id_setflag, rn: rn_p0, rm: rm_p0};
    end

    // Slot state is masked while reset is held so outputs go quiet immediately.
    assign ex_vld  = ex_p1.valid  & ~reset;
    assign mem_vld = mem_p2.valid & ~reset;
    assign wb_vld  = wb_p3.valid  & ~reset;

    assign ex_hit_a = id_rn_used & slot_match(ex_vld, ex_p1.wr, ex_p1.rd, rn_p0, ZR);
    assign ex_hit_b = id_rm_used & slot_match(ex_vld, ex_p1.wr, ex_p1.rd, rm_p0, ZR);
    assign mem_ld_a = id_rn_used & mem_p2.load
                      & slot_match(mem_vld, mem_p2.wr, mem_p2.rd, rn_p0, ZR);
    assign mem_ld_b = id_rm_used & mem_p2.load
                      & slot_match(mem_vld, mem_p2.wr, mem_p2.rd, rm_p0, ZR);

    assign load_use = (ex_hit_a | ex_hit_b) & ex_p1.load;
    assign cbr_haz  = id_cbr & (ex_hit_a | ex_hit_b | mem_ld_a | mem_ld_b);
    assign flag_haz = id_flagbr & ex_vld & ex_p1.setflag;

    assign stall       = load_use | cbr_haz | flag_haz;
    assign idex_bubble = stall;
    assign ifid_flush  = branch_taken & ~stall;

    pipe_fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_ex_a (
        .src(ex_p1.rn), .mem_valid(mem_vld), .mem_wr(mem_p2.wr), .mem_load(mem_p2.load),
        .mem_rd(mem_p2.rd), .wb_valid(wb_vld), .wb_wr(wb_p3.wr), .wb_rd(wb_p3.rd),
        .rf_data(ex_rf_a), .mem_data(mem_alu), .wb_data(wb_data),
        .sel(fwd_a_sel), .data(ex_opa)
    );

    pipe_fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_ex_b (
        .src(ex_p1.rm), .mem_valid(mem_vld), .mem_wr(mem_p2.wr), .mem_load(mem_p2.load),
        .mem_rd(mem_p2.rd), .wb_valid(wb_vld), .wb_wr(wb_p3.wr), .wb_rd(wb_p3.rd),
        .rf_data(ex_rf_b), .mem_data(mem_alu), .wb_data(wb_data),
        .sel(fwd_b_sel), .data(ex_opb)
    );

    // ID-side muxes feed the branch comparator; the WB match also covers write-through.
    pipe_fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_id_a (
        .src(rn_p0), .mem_valid(mem_vld), .mem_wr(mem_p2.wr), .mem_load(mem_p2.load),
        .mem_rd(mem_p2.rd), .wb_valid(wb_vld), .wb_wr(wb_p3.wr), .wb_rd(wb_p3.rd),
        .rf_data(id_rf_a), .mem_data(mem_alu), .wb_data(wb_data),
        .sel(id_sel_a), .data(id_opa)
    );

    pipe_fwd_mux #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_id_b (
        .src(rm_p0), .mem_valid(mem_vld), .mem_wr(mem_p2.wr), .mem_load(mem_p2.load),
        .mem_rd(mem_p2.rd), .wb_valid(wb_vld), .wb_wr(wb_p3.wr), .wb_rd(wb_p3.rd),
        .rf_data(id_rf_b), .mem_data(mem_alu), .wb_data(wb_data),
        .sel(id_sel_b), .data(id_opb)
    );

    // ID -> EX (_p1) -> MEM (_p2) -> WB (_p3); a stall injects a bubble into EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_p1  <= nop_slot(ZR);
            mem_p2 <= nop_slot(ZR);
            wb_p3  <= nop_slot(ZR);
        end else begin
            wb_p3  <= mem_p2;
            mem_p2 <= ex_p1;
            ex_p1  <= stall ? nop_slot(ZR) : id_p0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= sat_inc(perf_stall_cnt, stall);
            perf_flush_cnt <= sat_inc(perf_flush_cnt, ifid_flush);
        end
    end
`endif

    logic unused_fields;
    assign unused_fields = ^{mem_p2.setflag, mem_p2.rn, mem_p2.rm, wb_p3.load,
                             wb_p3.setflag, wb_p3.rn, wb_p3.rm, id_sel_a, id_sel_b};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed instruction stream, one
// expected record per cycle, checked by an independent negedge monitor.
module tb_pipe_hazard_unit;

    localparam logic [63:0] EXA  = 64'hA0;
    localparam logic [63:0] EXB  = 64'hB0;
    localparam logic [63:0] IDA  = 64'hA1;
    localparam logic [63:0] IDB  = 64'hB1;
    localparam logic [63:0] MEMV = 64'h5;
    localparam logic [63:0] WDEF = 64'hDEAD;

    typedef struct packed {
        logic [4:0] rn, rm;
        logic       rnu, rmu;
        logic [4:0] rd;
        logic       wr, ld, sf, fbr, cbr;
    } id_t;

    typedef struct packed {
        logic       stall, flush;
        logic [1:0] sa, sb, ia, ib;
    } code_t;

    typedef struct {
        code_t       c;
        logic [63:0] eopa, eopb, iopa, iopb;
        int          cyc;
    } exp_t;

    logic        clk, reset;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_rn_used, id_rm_used, id_wr, id_load, id_setflag, id_flagbr, id_cbr;
    logic        branch_taken;
    logic [63:0] mem_alu, wb_data, ex_rf_a, ex_rf_b, id_rf_a, id_rf_b;
    logic [63:0] ex_opa, ex_opb, id_opa, id_opb;
    logic        stall, idex_bubble, ifid_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    pipe_hazard_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_setflag(id_setflag),
        .id_flagbr(id_flagbr), .id_cbr(id_cbr), .branch_taken(branch_taken),
        .mem_alu(mem_alu), .wb_data(wb_data), .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .id_rf_a(id_rf_a), .id_rf_b(id_rf_b),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .id_opa(id_opa), .id_opb(id_opb),
        .stall(stall), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_t nop_i();
        id_t i;
        i    = '0;
        i.rn = 5'd31;
        i.rm = 5'd31;
        i.rd = 5'd31;
        return i;
    endfunction

    function automatic id_t alu(input int rd, input int rn, input int rm);
        id_t i;
        i     = nop_i();
        i.rd  = 5'(rd);
        i.rn  = 5'(rn);
        i.rm  = 5'(rm);
        i.rnu = 1'b1;
        i.rmu = 1'b1;
        i.wr  = 1'b1;
        return i;
    endfunction

    function automatic id_t subs(input int rd, input int rn, input int rm);
        id_t i;
        i    = alu(rd, rn, rm);
        i.sf = 1'b1;
        return i;
    endfunction

    function automatic id_t ldur(input int rd, input int rn);
        id_t i;
        i     = nop_i();
        i.rd  = 5'(rd);
        i.rn  = 5'(rn);
        i.rnu = 1'b1;
        i.wr  = 1'b1;
        i.ld  = 1'b1;
        return i;
    endfunction

    function automatic id_t beq();
        id_t i;
        i     = nop_i();
        i.fbr = 1'b1;
        return i;
    endfunction

    function automatic id_t cbz(input int rt);
        id_t i;
        i     = nop_i();
        i.rn  = 5'(rt);
        i.rnu = 1'b1;
        i.cbr = 1'b1;
        return i;
    endfunction

    function automatic code_t C(input logic s, input logic f, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] ia, input logic [1:0] ib);
        return '{stall: s, flush: f, sa: sa, sb: sb, ia: ia, ib: ib};
    endfunction

    function automatic logic [63:0] pick(input logic [1:0] s, input logic [63:0] rf,
                                         input logic [63:0] m, input logic [63:0] w);
        case (s)
            2'd1:    return m;
            2'd2:    return w;
            default: return rf;
        endcase
    endfunction

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, want);
        end
    endtask

    task automatic drive(input id_t i, input logic rv, input logic bt, input logic [63:0] wb,
                         input logic do_chk, input code_t c);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rv;
        id_rn        = i.rn;
        id_rm        = i.rm;
        id_rn_used   = i.rnu;
        id_rm_used   = i.rmu;
        id_rd        = i.rd;
        id_wr        = i.wr;
        id_load      = i.ld;
        id_setflag   = i.sf;
        id_flagbr    = i.fbr;
        id_cbr       = i.cbr;
        branch_taken = bt;
        wb_data      = wb;
        if (do_chk) begin
            e.c    = c;
            e.eopa = pick(c.sa, EXA, MEMV, wb);
            e.eopb = pick(c.sb, EXB, MEMV, wb);
            e.iopa = pick(c.ia, IDA, MEMV, wb);
            e.iopb = pick(c.ib, IDB, MEMV, wb);
            e.cyc  = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic step(input id_t i, input code_t c);
        drive(i, 1'b0, 1'b0, WDEF, 1'b1, c);
    endtask

    task automatic stepb(input id_t i, input logic bt, input logic [63:0] wb, input code_t c);
        drive(i, 1'b0, bt, wb, 1'b1, c);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",       e.cyc, 64'(stall),       64'(e.c.stall));
            chk("idex_bubble", e.cyc, 64'(idex_bubble), 64'(e.c.stall));
            chk("ifid_flush",  e.cyc, 64'(ifid_flush),  64'(e.c.flush));
            chk("fwd_a_sel",   e.cyc, 64'(fwd_a_sel),   64'(e.c.sa));
            chk("fwd_b_sel",   e.cyc, 64'(fwd_b_sel),   64'(e.c.sb));
            chk("ex_opa",      e.cyc, ex_opa,           e.eopa);
            chk("ex_opb",      e.cyc, ex_opb,           e.eopb);
            chk("id_opa",      e.cyc, id_opa,           e.iopa);
            chk("id_opb",      e.cyc, id_opb,           e.iopb);
        end
    end

    initial begin
        int guard;
        code_t z;
        z            = C(0, 0, 0, 0, 0, 0);
        reset        = 1'b1;
        {id_rn, id_rm, id_rd} = {5'd31, 5'd31, 5'd31};
        {id_rn_used, id_rm_used, id_wr, id_load, id_setflag, id_flagbr, id_cbr} = '0;
        branch_taken = 1'b0;
        mem_alu      = MEMV;
        wb_data      = WDEF;
        ex_rf_a      = EXA;
        ex_rf_b      = EXB;
        id_rf_a      = IDA;
        id_rf_b      = IDB;

        drive(nop_i(), 1'b1, 1'b0, WDEF, 1'b1, z);         // c0 reset
        step(alu(1, 2, 3),   z);                           // ADD X1,X2,X3
        step(alu(4, 1, 5),   z);                           // SUB X4,X1,X5
        step(nop_i(),        C(0, 0, 1, 0, 0, 0));         // SUB in EX takes X1 from MEM
        step(nop_i(),        z);
        step(ldur(1, 2),     z);                           // LDUR X1
        step(alu(4, 1, 1),   C(1, 0, 0, 0, 0, 0));         // load-use stall
        step(alu(4, 1, 1),   z);
        step(nop_i(),        C(0, 0, 2, 2, 0, 0));         // ADD in EX takes X1 from WB
        step(alu(31, 2, 3),  z);                           // write XZR
        step(alu(5, 31, 31), z);
        step(alu(6, 31, 2),  z);
        step(nop_i(),        z);
        step(subs(7, 8, 9),  z);                           // SUBS
        stepb(beq(), 1'b1, WDEF, C(1, 0, 0, 0, 0, 0));     // B.EQ stalled, flush held off
        stepb(beq(), 1'b1, WDEF, C(0, 1, 0, 0, 0, 0));     // flush now
        step(alu(10, 7, 2),  C(0, 0, 0, 0, 2, 0));         // ID reads X7 from WB
        step(ldur(7, 2),     z);                           // LDUR X7
        step(alu(11, 2, 3),  z);
        stepb(cbz(7), 1'b1, WDEF,  C(1, 0, 0, 0, 0, 0));   // CBZ behind MEM load
        stepb(cbz(7), 1'b1, 64'h0, C(0, 1, 0, 0, 2, 0));   // X7=0 from WB, flush
        step(nop_i(),        z);
        step(alu(12, 2, 3),  z);
        step(alu(12, 4, 5),  z);
        step(alu(13, 12, 12), C(0, 0, 0, 0, 1, 1));        // ID takes X12 from MEM
        step(alu(14, 12, 2), C(0, 0, 1, 1, 1, 0));         // MEM beats WB
        step(cbz(14),        C(1, 0, 2, 0, 0, 0));         // CBZ behind EX writer
        step(cbz(14),        C(0, 0, 0, 0, 1, 0));
        step(ldur(15, 2),    C(0, 0, 2, 0, 0, 0));
        step(ldur(16, 15),   C(1, 0, 0, 0, 0, 0));         // chained load-use
        step(ldur(16, 15),   z);
        step(alu(17, 16, 2), C(1, 0, 2, 0, 0, 0));
        step(alu(17, 16, 2), z);
        step(nop_i(),        C(0, 0, 2, 0, 0, 0));
        step(ldur(18, 2),    z);
        step(alu(19, 18, 2), C(1, 0, 0, 0, 0, 0));         // stall, then reset
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("perf_stall_pre", cyc, 64'(perf_stall_cnt), 64'd6);
        chk("perf_flush_pre", cyc, 64'(perf_flush_cnt), 64'd2);
`endif
        drive(alu(19, 18, 2), 1'b1, 1'b0, WDEF, 1'b0, z);
        step(alu(19, 18, 2), z);                           // stall gone, slots empty
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("perf_stall_rst", cyc, 64'(perf_stall_cnt), 64'd0);
        chk("perf_flush_rst", cyc, 64'(perf_flush_cnt), 64'd0);
`endif
        step(nop_i(),        z);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard, stall and forwarding controller for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
- Tracks destination and source registers of in-flight instructions in an internal EX/MEM/WB shadow pipeline.
- Drives PC/IF_ID stalls, ID_EX bubble insertion and IF_ID flush on taken ID-stage branches.
- Produces operand-forwarding selects for the EX ALU and the ID branch comparator.
- Replaces free-running pipeline registers with hazard-correct control for arbitrary data width and register-file size.

Parameters:
- DATA_W, 64, datapath width of forwarded operands.
- REG_AW, 5, register index width (2**REG_AW registers).
- ZERO_REG, 31, index of XZR; never forwarded, never a hazard source.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge with reset=1.
- id_rn, id_rm  in  REG_AW  ID source register indices.
- id_rn_used, id_rm_used  in  1  source actually read by the ID instruction.
- id_rd  in  REG_AW  ID destination index.
- id_wr  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is LDUR.
- id_setflag  in  1  ID instruction sets NZVC.
- id_flagbr  in  1  ID instruction is a flag-conditional branch (B.EQ/NE/LT/GE).
- id_cbr  in  1  ID instruction is CBZ/CBNZ (reads a register in ID).
- branch_taken  in  1  raw taken decision from the ID branch checker.
- mem_alu  in  DATA_W  MEM-stage ALU result.
- wb_data  in  DATA_W  WB-stage writeback data (post load mux).
- ex_rf_a, ex_rf_b  in  DATA_W  EX operands from ID_EX.
- id_rf_a, id_rf_b  in  DATA_W  ID register-file outputs.
- ex_opa, ex_opb  out  DATA_W  forwarded EX operands.
- id_opa, id_opb  out  DATA_W  forwarded ID branch-compare operands.
- stall  out  1  hold PC and IF_ID.
- idex_bubble  out  1  load NOP into ID_EX.
- ifid_flush  out  1  load NOP into IF_ID.
- fwd_a_sel, fwd_b_sel  out  2  EX select: 0 = regfile, 1 = MEM, 2 = WB.

Behaviour:
- Shadow slots EX, MEM and WB each hold {valid, rd, wr, load, setflag, rn, rm}.
- Every edge: WB<=MEM; MEM<=EX; EX<=ID fields, or an invalid bubble when stall=1.
- The slot update ignores ifid_flush; the flushed instruction is the one in IF, not ID.
- match(s, r) = s.valid & s.wr & s.rd==r & r!=ZERO_REG.
- EX forwarding, per operand: MEM-slot match (non-load) -> sel 1 / mem_alu; else WB-slot match -> sel 2 / wb_data; else sel 0. MEM has priority over WB.
- Stall (combinational, one-cycle granularity):
  - load-use: a used ID source matches an EX slot with load=1.
  - compare-branch: id_cbr & (source matches the EX slot, or matches the MEM slot with load=1).
  - flag-branch: id_flagbr & EX.valid & EX.setflag.
- stall implies idex_bubble=1.
- ID forwarding (id_opa/id_opb): MEM non-load match -> mem_alu; WB match -> wb_data; else regfile. Priority MEM > WB. Same-cycle WB write/ID read is covered by the WB match.
- ifid_flush = branch_taken & ~stall. A branch raised during a stall is ignored and is re-evaluated the next cycle.
- Latency: stall, forwarding and flush are combinational from slot state. Slots update with 1-cycle latency.
- Reset: all slots invalid. Outputs during and after reset: stall=0, idex_bubble=0, ifid_flush=0 (with branch_taken=0), sel=0, operands pass through.
- Reset asserted mid-stall drops the stall on the next cycle.
- Back-to-back load-use in one chain gives exactly one bubble per dependent instruction.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt (32 bits each). They increment on cycles with stall=1 and ifid_flush=1 respectively, saturate at 2**32-1 and clear on reset.
- Undefined: the ports and counters are absent.

Decomposition:
Shared package pipe_pkg holds:
- the slot struct typedef,
- the fwd-select enum (FWD_RF, FWD_MEM, FWD_WB),
- the ZERO_REG default,
- the NOP encoding.

One sub-module, pipe_fwd_mux (match priority plus 3:1 select), is instantiated four times (EX a/b, ID a/b).

Test Plan:
1. ADD X1,X2,X3 then SUB X4,X1,X5 -> second cycle in EX: fwd_a_sel=1, ex_opa=mem_alu=0x5; no stall.
2. LDUR X1 then ADD X4,X1,X1 -> stall=1 and idex_bubble=1 for exactly one cycle; then fwd_a_sel=fwd_b_sel=2, ex_opa=wb_data=0xDEAD.
3. ADD X31,... then use X31 -> fwd_a_sel=0, stall=0 (XZR never forwarded).
4. SUBS then B.EQ immediately -> one stall cycle; branch_taken=1 during stall gives ifid_flush=0, then ifid_flush=1 the following cycle.
5. CBZ X7 two instructions after LDUR X7 -> one stall; id_opa=wb_data=0 then branch flush.
6. reset pulsed mid-load-use stall -> next cycle stall=0, all sel=0, slots invalid; (EN build) perf counters read 0.
